// File: rtl/lm_sm_sequencer_if.sv
// lm_sm_sequencer_if
// Bundles the LM/SM sequencer's request, status, data-memory and
// register-file signals.
//   master : the sequencer side (takes requests and read data, drives the
//            status flags, memory strobes and register-file ports).
//   slave  : the execute stage / memory / register-file side.
// Request : start, is_store, base_addr[AW], reg_mask[8], base_reg[3], flush
// Status  : busy, stall, done, r7_loaded
// Memory  : mem_en, mem_wr, mem_addr[AW], mem_wdata[DW], mem_rdata[DW]
// RegFile : rf_rd_addr[3], rf_rd_data[DW], rf_wr_en, rf_wr_addr[3], rf_wr_data[DW]
interface lm_sm_sequencer_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          start;
  logic          is_store;
  logic [AW-1:0] base_addr;
  logic [7:0]    reg_mask;
  logic [2:0]    base_reg;
  logic          flush;
  logic          busy;
  logic          stall;
  logic          done;
  logic          r7_loaded;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [2:0]    rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic          rf_wr_en;
  logic [2:0]    rf_wr_addr;
  logic [DW-1:0] rf_wr_data;

  modport master (
    input  start, is_store, base_addr, reg_mask, base_reg, flush,
    input  mem_rdata, rf_rd_data,
    output busy, stall, done, r7_loaded,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data
  );

  modport slave (
    output start, is_store, base_addr, reg_mask, base_reg, flush,
    output mem_rdata, rf_rd_data,
    input  busy, stall, done, r7_loaded,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer
// Multi-cycle sequencer for load-multiple / store-multiple. On an accepted
// start it walks the register mask from R0 upwards, issuing one data-memory
// access per set bit at consecutive addresses, and drives the register-file
// write port (LM) or read port (SM). The upstream pipe is stalled meanwhile.
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous, active-high reset
//   bus        : lm_sm_sequencer_if.master (request, status, memory, regfile)
// Optional feature (macro LMSM_BASE_WB_EN): adds a WB state that writes
// base_addr + transfer count back into the base register, skipped when an LM
// also loads the base register.
module lm_sm_sequencer #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  lm_sm_sequencer_if.master    bus
);

`ifdef LMSM_BASE_WB_EN
  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;
  localparam state_t EMPTY_NEXT = WB;
`else
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  localparam state_t EMPTY_NEXT = DONE;
`endif

  state_t        state, state_nx;
  logic          op_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] base_addr_q;
  logic [7:0]    mask_q;
  logic [7:0]    orig_mask_q;
  logic [2:0]    base_q;
  logic [3:0]    cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          r7_q;

  logic [2:0]    idx;
  logic          idx_found;
  logic [7:0]    mask_nx;
  logic          abort;
  logic          accept;
  logic [DW-1:0] wb_data;

  // Lowest set bit of the remaining mask.
  always_comb begin
    idx       = '0;
    idx_found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (mask_q[i[2:0]] && !idx_found) begin
        idx       = i[2:0];
        idx_found = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit: x & (x-1).
  assign mask_nx = mask_q & (mask_q - 8'd1);
  assign abort   = bus.flush | reset;
  assign accept  = (state == IDLE) & bus.start;
  assign wb_data = DW'(base_addr_q + AW'(cnt_q));

`ifdef LMSM_BASE_WB_EN
  logic wb_skip;
  assign wb_skip = ~op_q & orig_mask_q[base_q];
`else
  logic unused_wb;
  assign unused_wb = ^{base_q, orig_mask_q[6:0], wb_data};
`endif

  always_comb begin
    state_nx       = state;
    bus.mem_en     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.rf_rd_addr = '0;
    bus.rf_wr_en   = 1'b0;
    bus.rf_wr_addr = '0;
    bus.rf_wr_data = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.reg_mask != '0) state_nx = XFER;
          else                    state_nx = EMPTY_NEXT;
        end
      end
      XFER: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = addr_q;
          if (op_q) begin
            bus.rf_rd_addr = idx;
            bus.mem_wr     = 1'b1;
          end else begin
            bus.rf_wr_en   = 1'b1;
            bus.rf_wr_addr = idx;
            bus.rf_wr_data = bus.mem_rdata;
          end
`ifdef LMSM_BASE_WB_EN
          if (mask_nx == '0) state_nx = wb_skip ? DONE : WB;
`else
          if (mask_nx == '0) state_nx = DONE;
`endif
        end
      end
`ifdef LMSM_BASE_WB_EN
      WB: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          bus.rf_wr_en   = 1'b1;
          bus.rf_wr_addr = base_q;
          bus.rf_wr_data = wb_data;
          state_nx       = DONE;
        end
      end
`endif
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= 1'b0;
      addr_q      <= '0;
      base_addr_q <= '0;
      mask_q      <= '0;
      orig_mask_q <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      r7_q        <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx != IDLE) & (state_nx != DONE);
      done_q <= (state_nx == DONE);
      // An empty-mask request never has bit 7, so only non-IDLE entries matter.
      r7_q   <= (state_nx == DONE) & (state != IDLE) & ~op_q & orig_mask_q[7];
      if (accept) begin
        op_q        <= bus.is_store;
        addr_q      <= bus.base_addr;
        base_addr_q <= bus.base_addr;
        mask_q      <= bus.reg_mask;
        orig_mask_q <= bus.reg_mask;
        base_q      <= bus.base_reg;
        cnt_q       <= '0;
      end else if (state == XFER && !bus.flush) begin
        mask_q <= mask_nx;
        addr_q <= addr_q + AW'(1);
        cnt_q  <= cnt_q + 4'd1;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.r7_loaded = r7_q;
  assign bus.stall     = (state == XFER) | (state == DONE ? 1'b0 : (state != IDLE)) | accept;
  assign bus.mem_wdata = bus.rf_rd_data;

endmodule

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Multi-cycle sequencer for the load-multiple (LM) and store-multiple (SM) instructions. It takes a base address and an 8-bit register mask from the execute stage. It then issues one data-memory access per set mask bit, in ascending register order, and drives the register-file write port (LM) or read port (SM) for each access. While it runs, it holds the upstream pipeline stalled. This replaces the per-stage priority-encoder stepping that is spread across the pipeline registers.

## Interface
Parameters:
- `AW`, 16: data-memory address width.
- `DW`, 16: data and register width.

Ports:
- `clock`  in  1  system clock. Everything updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `is_store`  in  1  1 = SM, 0 = LM. Captured when `start` is accepted.
- `base_addr`  in  AW  first memory address. Captured on `start`.
- `reg_mask`  in  8  bit i = transfer register Ri. Captured on `start`.
- `base_reg`  in  3  index of the base register. Captured on `start`. Used only with `LMSM_BASE_WB_EN`.
- `flush`  in  1  abort the current sequence, e.g. on a branch mispredict older in the pipe.
- `busy`  out  1  registered. High in XFER and WB.
- `stall`  out  1  combinational. Equals `(state==XFER) | (state==WB) | (state==IDLE & start)`.
- `done`  out  1  registered one-cycle pulse. High in DONE.
- `r7_loaded`  out  1  registered. Pulses with `done` when an LM mask had bit 7 set.
- `mem_en`  out  1  data-memory access enable.
- `mem_wr`  out  1  data-memory write strobe. Write occurs at the clock edge.
- `mem_addr`  out  AW  data-memory address.
- `mem_wdata`  out  DW  equals `rf_rd_data`.
- `mem_rdata`  in  DW  combinational read data for `mem_addr`.
- `rf_rd_addr`  out  3  register-file read index (SM).
- `rf_rd_data`  in  DW  combinational register read data.
- `rf_wr_en`  out  1  register-file write enable.
- `rf_wr_addr`  out  3  register-file write index.
- `rf_wr_data`  out  DW  register-file write data.

## Operation
States: IDLE, XFER, WB, DONE.

- **IDLE**
  - `start`=1 captures `is_store`, `base_addr`, `reg_mask` and `base_reg` into `op_q`, `addr_q`, `mask_q` and `base_q`.
  - `cnt_q` is cleared.
  - Next state is XFER if `mask_q` is non-zero, otherwise WB (macro on) or DONE (macro off).
- **XFER**
  - `idx` is the lowest set bit of `mask_q`.
  - Outputs this cycle:
    - `mem_en`=1 and `mem_addr=addr_q`.
    - SM: `rf_rd_addr=idx` and `mem_wr`=1.
    - LM: `rf_wr_en`=1, `rf_wr_addr=idx` and `rf_wr_data=mem_rdata`.
  - At the clock edge:
    - clear bit `idx` in `mask_q`;
    - `addr_q` increments by 1, mod 2^AW; 0xFFFF wraps to 0x0000;
    - `cnt_q` increments by 1 (4-bit, maximum 8).
  - Exit when the cleared mask becomes 0.
- **WB** (only with the macro; see Configuration). One cycle, then DONE.
- **DONE**
  - `done`=1 and `r7_loaded` = (LM and original mask bit 7).
  - No memory or register-file strobes.
  - Unconditionally returns to IDLE. `start` is ignored in DONE.
- Memory and register-file strobes (`mem_en`, `mem_wr`, `rf_wr_en`) are 0 in IDLE and DONE.
- `start` while `busy` is ignored and has no effect on captured state.
- `flush` in any non-IDLE state:
  - strobes are forced to 0 that cycle;
  - next state is IDLE, with no `done` and no `r7_loaded`.
- If `flush` and `start` arrive together in IDLE, `start` wins.
- `reset` mid-sequence behaves like `flush` and also clears all registers.

## Timing
- Reset values: state IDLE; `busy`, `done` and `r7_loaded` are 0; all strobes 0; `mem_addr`, `rf_rd_addr`, `rf_wr_addr` and `rf_wr_data` are 0; `mask_q`, `addr_q` and `cnt_q` are 0.
- With `start` accepted at edge 0 and N = popcount(mask):
  - XFER covers cycles 1..N;
  - WB, if compiled in, is cycle N+1;
  - `done` is high in cycle N+1, or N+2 with WB.
- Empty mask: `done` in cycle 1, or 2 with WB. No memory access.
- Throughput: one transfer per cycle. No back-to-back overlap; the minimum gap between `done` and the next accepted `start` is one cycle (DONE→IDLE).
- `stall` rises combinationally in the `start` cycle. It falls in the DONE cycle.

## Configuration
- `LMSM_BASE_WB_EN` defined:
  - The WB state exists.
  - In WB, `rf_wr_en`=1, `rf_wr_addr=base_q` and `rf_wr_data=base_addr_captured + cnt_q`.
  - WB is skipped entirely (XFER goes straight to DONE) when the op is LM and `base_q` is set in the original mask. The loaded value wins.
- `LMSM_BASE_WB_EN` undefined:
  - The WB state does not exist.
  - XFER (or IDLE with an empty mask) goes directly to DONE.
  - The base register is never written.

## Test plan
- **LM, base 0x0040, mask 0x25**:
  - cycles 1–3 read 0x0040, 0x0041 and 0x0042;
  - they write R0, R2 and R5 with the memory contents;
  - `done` in cycle 4 (macro off), `r7_loaded`=0.
- **SM, base 0x0100, mask 0x81**, R0=0x1111, R7=0x7777:
  - mem[0x0100]=0x1111 and mem[0x0101]=0x7777;
  - `mem_wr` is high exactly 2 cycles.
- **Wrap**: LM, base 0xFFFF, mask 0x03 → addresses 0xFFFF then 0x0000.
- **Empty mask 0x00**: `done` in cycle 1 (2 with the macro), `mem_en` never asserted, and `stall` is high only in the `start` cycle (plus WB).
- **Flush**: LM with mask 0xFF, `flush` in cycle 3 → R0 and R1 written, R2 not written, no `done`, and IDLE in cycle 4. A `start` in cycle 4 is accepted.
- **With `LMSM_BASE_WB_EN`**:
  - SM, base_reg=R3, base 0x0200, mask 0x0E → R3=0x0203 after WB.
  - LM with base_reg=R1, mask 0x02 → R1 keeps the loaded value and there is no WB cycle.
